// File: rtl/svc_uart_pkg.sv
// Shared UART definitions for the svc_uart_* blocks.
//   UART_DATA_BITS : data bits per frame (8N1 framing)
//   uart_state_t   : receiver/transmitter bit-phase state
//   clks_per_bit() : integer clocks per line bit for a given clock and baud
package svc_uart_pkg;

   localparam int unsigned UART_DATA_BITS = 8;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_t;

   function automatic int unsigned clks_per_bit(input int unsigned freq,
                                                input int unsigned baud);
      return freq / baud;
   endfunction

endpackage

// File: rtl/svc_sync_bit.sv
// Two-flop synchronizer for a single asynchronous input bit.
//   clk   : destination clock
//   rst   : synchronous active-high reset, loads RESET_VAL into both flops
//   d     : asynchronous input
//   q     : synchronized output, two cycles of latency
module svc_sync_bit #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/svc_uart_rx.sv
// 8N1 UART receiver producing a valid/ready byte stream.
//   clk           : system clock (CLOCK_FREQ Hz)
//   rst           : synchronous active-high reset
//   urx_pin       : asynchronous serial line, idles high
//   urx_valid     : received byte available on urx_data
//   urx_data      : received byte, held stable while urx_valid is high
//   urx_ready     : consumer accepts the byte when urx_valid & urx_ready
//   urx_frame_err : one-cycle pulse, stop bit sampled low (byte dropped)
//   urx_overrun   : one-cycle pulse, completed byte dropped because the
//                   previous byte was still waiting to be accepted
module svc_uart_rx
   import svc_uart_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ = 25_000_000,
   parameter int unsigned BAUD_RATE  = 115_200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       urx_pin,
   output logic       urx_valid,
   output logic [7:0] urx_data,
   input  logic       urx_ready,
   output logic       urx_frame_err,
   output logic       urx_overrun
);

   localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W        = $clog2(UART_DATA_BITS);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(UART_DATA_BITS - 1);

   if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("svc_uart_rx: CLKS_PER_BIT=%0d, must be at least 4", CLKS_PER_BIT);
   end

   logic                       rx_s;
   uart_state_t                state, state_nxt;
   logic [CNT_W-1:0]           cnt, cnt_nxt;
   logic [BIT_W-1:0]           bit_cnt, bit_nxt;
   logic [UART_DATA_BITS-1:0]  shift, shift_nxt;
   logic                       valid_nxt;
   logic [7:0]                 data_nxt;
   logic                       ferr_nxt;
   logic                       ovr_nxt;
   logic [1:0]                 settle;
   logic                       armed;

   svc_sync_bit #(
      .RESET_VAL(1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (urx_pin),
      .q   (rx_s)
   );

   // After reset the synchronizer holds its reset value for two cycles, so a
   // line that is really low (reset landed mid-frame) would look like a fresh
   // falling edge. Start detection is armed only once the real line has been
   // seen high, so the tail of an interrupted frame is never decoded.
   always_ff @(posedge clk) begin
      if (rst) begin
         settle <= '0;
         armed  <= 1'b0;
      end else begin
         settle <= {settle[0], 1'b1};
         if (settle[1] && rx_s) begin
            armed <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         bit_cnt       <= '0;
         shift         <= '0;
         urx_valid     <= 1'b0;
         urx_data      <= '0;
         urx_frame_err <= 1'b0;
         urx_overrun   <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         bit_cnt       <= bit_nxt;
         shift         <= shift_nxt;
         urx_valid     <= valid_nxt;
         urx_data      <= data_nxt;
         urx_frame_err <= ferr_nxt;
         urx_overrun   <= ovr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      bit_nxt   = bit_cnt;
      shift_nxt = shift;
      valid_nxt = urx_valid;
      data_nxt  = urx_data;
      ferr_nxt  = 1'b0;
      ovr_nxt   = 1'b0;

      if (urx_valid && urx_ready) begin
         valid_nxt = 1'b0;
      end

      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (!rx_s && armed) begin
               state_nxt = START;
            end
         end

         START: begin
            if (cnt == HALF_LAST) begin
               cnt_nxt   = '0;
               bit_nxt   = '0;
               state_nxt = rx_s ? IDLE : DATA;
            end
         end

         DATA: begin
            if (cnt == FULL_LAST) begin
               cnt_nxt            = '0;
               shift_nxt[bit_cnt] = rx_s;
               if (bit_cnt == LAST_BIT) begin
                  state_nxt = STOP;
               end else begin
                  bit_nxt = bit_cnt + 1'b1;
               end
            end
         end

         STOP: begin
            // Leaving at mid stop bit gives half a bit of slack for the next
            // start edge, which absorbs baud mismatch on back-to-back frames.
            if (cnt == FULL_LAST) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
               if (!rx_s) begin
                  ferr_nxt = 1'b1;
               end else if (urx_valid && !urx_ready) begin
                  ovr_nxt = 1'b1;
               end else begin
                  data_nxt  = shift;
                  valid_nxt = 1'b1;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_svc_uart_rx.sv
module tb_svc_uart_rx;

   localparam int unsigned CF  = 1_000_000;
   localparam int unsigned BR  = 100_000;
   localparam int unsigned CPB = CF / BR;
   // Start bit drops at cycle c0; the byte becomes visible after edge c0+LAT:
   // 2 sync cycles + CPB/2 + 9*CPB + 1.
   localparam int unsigned LAT = 2 + CPB / 2 + 9 * CPB + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       urx_pin;
   logic       urx_valid;
   logic [7:0] urx_data;
   logic       urx_ready;
   logic       urx_frame_err;
   logic       urx_overrun;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc = 0;

   always #5 clk = ~clk;

   svc_uart_rx #(
      .CLOCK_FREQ(CF),
      .BAUD_RATE (BR)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .urx_pin      (urx_pin),
      .urx_valid    (urx_valid),
      .urx_data     (urx_data),
      .urx_ready    (urx_ready),
      .urx_frame_err(urx_frame_err),
      .urx_overrun  (urx_overrun)
   );

   // Observation log: accepted bytes with the cycle they were first on the
   // bus, plus pulse cycles of the two error flags.
   logic [7:0]  acc_data[$];
   int unsigned acc_cyc[$];
   int unsigned ferr_cyc[$];
   int unsigned ovr_cyc[$];
   int unsigned vcnt;
   logic        prev_valid = 1'b0;
   logic [7:0]  prev_data  = '0;
   int unsigned first_seen = 0;

   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      // ready only changes on negedges, so its value now is what the DUT saw
      // on this edge together with the previous cycle's valid/data.
      if (prev_valid && urx_ready) begin
         acc_data.push_back(prev_data);
         acc_cyc.push_back(first_seen);
      end
      if (urx_valid && !(prev_valid && !urx_ready && prev_data == urx_data))
         first_seen = cyc;
      if (urx_valid)     vcnt = vcnt + 1;
      if (urx_frame_err) ferr_cyc.push_back(cyc);
      if (urx_overrun)   ovr_cyc.push_back(cyc);
      prev_valid = urx_valid;
      prev_data  = urx_data;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic clear_log();
      acc_data.delete();
      acc_cyc.delete();
      ferr_cyc.delete();
      ovr_cyc.delete();
      vcnt = 0;
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one 8N1 frame starting at the current negedge; c0 = drop cycle.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             output int unsigned c0);
      c0 = cyc;
      urx_pin = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         urx_pin = b[i];
         repeat (CPB) @(negedge clk);
      end
      urx_pin = stop_bit;
      repeat (CPB) @(negedge clk);
      urx_pin = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle(2);
      checks++; if (urx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", urx_valid); end
      checks++; if (urx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", urx_data); end
      checks++; if (urx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", urx_frame_err); end
      checks++; if (urx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", urx_overrun); end
      rst = 1'b0;
      idle(6);
   endtask

   task automatic test_single();
      int unsigned c0;
      clear_log();
      urx_ready = 1'b1;
      send_frame(8'h55, 1'b1, c0);
      idle(5);
      checks++; if (acc_data.size() != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", acc_data.size()); end
      checks++; if (acc_data.size() < 1 || acc_data[0] !== 8'h55) begin errors++; $display("FAIL single_data: got %h expected 55", acc_data.size() ? acc_data[0] : 8'hxx); end
      checks++; if (acc_cyc.size() < 1 || acc_cyc[0] != c0 + LAT) begin errors++; $display("FAIL single_time: got %0d expected %0d", acc_cyc.size() ? acc_cyc[0] : 0, c0 + LAT); end
      checks++; if (vcnt != 1) begin errors++; $display("FAIL single_valid_width: got %0d expected 1", vcnt); end
      checks++; if (ferr_cyc.size() + ovr_cyc.size() != 0) begin errors++; $display("FAIL single_flags: got %0d expected 0", ferr_cyc.size() + ovr_cyc.size()); end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  bytes[3];
      int unsigned c0[3];
      bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hFF;
      clear_log();
      urx_ready = 1'b1;
      for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1, c0[i]);
      idle(5);
      checks++; if (acc_data.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", acc_data.size()); end
      for (int i = 0; i < 3; i++) begin
         if (i < acc_data.size()) begin
            checks++; if (acc_data[i] !== bytes[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, acc_data[i], bytes[i]); end
            checks++; if (acc_cyc[i] != c0[i] + LAT) begin errors++; $display("FAIL b2b_time[%0d]: got %0d expected %0d", i, acc_cyc[i], c0[i] + LAT); end
            if (i > 0) begin
               checks++; if (acc_cyc[i] - acc_cyc[i-1] != 10 * CPB) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", i, acc_cyc[i] - acc_cyc[i-1], 10 * CPB); end
            end
         end
      end
      checks++; if (ferr_cyc.size() + ovr_cyc.size() != 0) begin errors++; $display("FAIL b2b_flags: got %0d expected 0", ferr_cyc.size() + ovr_cyc.size()); end
   endtask

   task automatic test_random();
      logic [7:0]  exp_data[$];
      int unsigned exp_cyc[$];
      logic [7:0]  b;
      int unsigned c0;
      clear_log();
      urx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom);
         send_frame(b, 1'b1, c0);
         exp_data.push_back(b);
         exp_cyc.push_back(c0 + LAT);
         idle($urandom_range(12, 0));
      end
      idle(5);
      checks++; if (acc_data.size() != exp_data.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", acc_data.size(), exp_data.size()); end
      for (int i = 0; i < exp_data.size(); i++) begin
         if (i < acc_data.size()) begin
            checks++; if (acc_data[i] !== exp_data[i] || acc_cyc[i] != exp_cyc[i]) begin
               errors++; $display("FAIL rand_byte[%0d]: got %h@%0d expected %h@%0d", i, acc_data[i], acc_cyc[i], exp_data[i], exp_cyc[i]);
            end
         end
      end
      checks++; if (ferr_cyc.size() + ovr_cyc.size() != 0) begin errors++; $display("FAIL rand_flags: got %0d expected 0", ferr_cyc.size() + ovr_cyc.size()); end
   endtask

   task automatic test_overrun();
      int unsigned c0, c1;
      clear_log();
      urx_ready = 1'b0;
      send_frame(8'h12, 1'b1, c0);
      send_frame(8'h34, 1'b1, c1);
      idle(3);
      checks++; if (ovr_cyc.size() != 1 || ovr_cyc[0] != c1 + LAT) begin errors++; $display("FAIL ovr_pulse: got %0d pulses first@%0d expected 1@%0d", ovr_cyc.size(), ovr_cyc.size() ? ovr_cyc[0] : 0, c1 + LAT); end
      checks++; if (urx_valid !== 1'b1 || urx_data !== 8'h12) begin errors++; $display("FAIL ovr_held: got valid=%b data=%h expected valid=1 data=12", urx_valid, urx_data); end
      checks++; if (acc_data.size() != 0) begin errors++; $display("FAIL ovr_no_accept: got %0d expected 0", acc_data.size()); end
      urx_ready = 1'b1;
      idle(5);
      checks++; if (acc_data.size() != 1 || acc_data[0] !== 8'h12) begin errors++; $display("FAIL ovr_drain: got %0d bytes first=%h expected 1 byte 12", acc_data.size(), acc_data.size() ? acc_data[0] : 8'hxx); end
      checks++; if (urx_valid !== 1'b0) begin errors++; $display("FAIL ovr_empty: got %b expected 0", urx_valid); end
      checks++; if (ferr_cyc.size() != 0) begin errors++; $display("FAIL ovr_frame_err: got %0d expected 0", ferr_cyc.size()); end
   endtask

   // Old byte accepted in the same cycle the next byte completes.
   task automatic test_accept_collision();
      int unsigned c0, c1;
      clear_log();
      urx_ready = 1'b0;
      send_frame(8'h12, 1'b1, c0);
      c1 = cyc;
      fork
         send_frame(8'h56, 1'b1, c0);
         begin
            repeat (LAT - 1) @(negedge clk);
            urx_ready = 1'b1;
         end
      join
      idle(5);
      checks++; if (ovr_cyc.size() != 0) begin errors++; $display("FAIL coll_overrun: got %0d expected 0", ovr_cyc.size()); end
      checks++; if (acc_data.size() != 2) begin errors++; $display("FAIL coll_count: got %0d expected 2", acc_data.size()); end
      if (acc_data.size() == 2) begin
         checks++; if (acc_data[0] !== 8'h12 || acc_data[1] !== 8'h56) begin errors++; $display("FAIL coll_data: got %h,%h expected 12,56", acc_data[0], acc_data[1]); end
         checks++; if (acc_cyc[1] != c1 + LAT) begin errors++; $display("FAIL coll_time: got %0d expected %0d", acc_cyc[1], c1 + LAT); end
      end
   endtask

   task automatic test_frame_err();
      int unsigned c0, c1;
      clear_log();
      urx_ready = 1'b1;
      send_frame(8'h81, 1'b0, c0);
      idle(20);
      checks++; if (ferr_cyc.size() != 1 || ferr_cyc[0] != c0 + LAT) begin errors++; $display("FAIL ferr_pulse: got %0d pulses first@%0d expected 1@%0d", ferr_cyc.size(), ferr_cyc.size() ? ferr_cyc[0] : 0, c0 + LAT); end
      checks++; if (vcnt != 0) begin errors++; $display("FAIL ferr_no_valid: got %0d expected 0", vcnt); end
      send_frame(8'h7E, 1'b1, c1);
      idle(5);
      checks++; if (acc_data.size() != 1 || acc_data[0] !== 8'h7E || acc_cyc[0] != c1 + LAT) begin errors++; $display("FAIL ferr_recover: got %0d bytes first=%h expected 1 byte 7E@%0d", acc_data.size(), acc_data.size() ? acc_data[0] : 8'hxx, c1 + LAT); end
      checks++; if (ferr_cyc.size() != 1 || ovr_cyc.size() != 0) begin errors++; $display("FAIL ferr_extra_flags: got ferr=%0d ovr=%0d expected 1,0", ferr_cyc.size(), ovr_cyc.size()); end
   endtask

   task automatic test_glitch();
      int unsigned c0;
      clear_log();
      urx_ready = 1'b1;
      urx_pin = 1'b0;
      idle(3);
      urx_pin = 1'b1;
      idle(10);
      checks++; if (vcnt != 0 || ferr_cyc.size() != 0 || ovr_cyc.size() != 0) begin errors++; $display("FAIL glitch_quiet: got valid=%0d ferr=%0d ovr=%0d expected 0,0,0", vcnt, ferr_cyc.size(), ovr_cyc.size()); end
      send_frame(8'h00, 1'b1, c0);
      idle(5);
      checks++; if (acc_data.size() != 1 || acc_data[0] !== 8'h00 || acc_cyc[0] != c0 + LAT) begin errors++; $display("FAIL glitch_next: got %0d bytes first=%h expected 1 byte 00@%0d", acc_data.size(), acc_data.size() ? acc_data[0] : 8'hxx, c0 + LAT); end
   endtask

   task automatic test_reset_mid();
      int unsigned c0, c1;
      clear_log();
      urx_ready = 1'b1;
      fork
         send_frame(8'hC3, 1'b1, c0);
         begin
            repeat (CPB * 5 - CPB / 2) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
      join
      idle(20);
      checks++; if (vcnt != 0 || ferr_cyc.size() != 0 || ovr_cyc.size() != 0) begin errors++; $display("FAIL rstmid_quiet: got valid=%0d ferr=%0d ovr=%0d expected 0,0,0", vcnt, ferr_cyc.size(), ovr_cyc.size()); end
      send_frame(8'h5A, 1'b1, c1);
      idle(5);
      checks++; if (acc_data.size() != 1 || acc_data[0] !== 8'h5A || acc_cyc[0] != c1 + LAT) begin errors++; $display("FAIL rstmid_next: got %0d bytes first=%h expected 1 byte 5A@%0d", acc_data.size(), acc_data.size() ? acc_data[0] : 8'hxx, c1 + LAT); end
   endtask

   initial begin
      rst       = 1'b1;
      urx_pin   = 1'b1;
      urx_ready = 1'b1;
      vcnt      = 0;
      idle(3);
      test_reset();
      test_single();
      test_back_to_back();
      test_random();
      test_overrun();
      test_accept_collision();
      test_frame_err();
      test_glitch();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/svc_uart_rx.md
Name: svc_uart_rx

Overview:
- Serial-to-byte UART receiver. Sits directly downstream of the SoC's `uart_tx` pin in the simulation tops and in on-board loopback.
- Decodes 8N1 frames into a valid/ready byte stream, so benches and on-chip consumers see characters instead of raw line samples.
- Flags framing errors and overruns. Gives the sim harness a synthesizable path for checking firmware console output.

Parameters:
- CLOCK_FREQ, 25_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, line rate in bits/s.
- CLKS_PER_BIT, CLOCK_FREQ/BAUD_RATE (derived localparam), clocks per bit. Elaboration error if < 4.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- urx_pin  input  1  asynchronous serial line; idles high.
- urx_valid  output  1  byte available.
- urx_data  output  8  received byte; stable while urx_valid=1.
- urx_ready  input  1  consumer accepts byte when urx_valid & urx_ready.
- urx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- urx_overrun  output  1  one-cycle pulse: completed byte dropped because the output was still full.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - urx_valid=0, urx_data=0, urx_frame_err=0, urx_overrun=0.
  - Synchronizer flops reset to 1.
  - FSM resets to IDLE; bit counter and clock counter reset to 0.
- Input sync: urx_pin passes through 2 flops (`rx_s`). All decisions use `rx_s`, so there are 2 cycles of input latency.
- FSM states and transitions:
  - IDLE: on `rx_s`==0 → START, clock counter=0.
  - START: when counter reaches CLKS_PER_BIT/2−1 (mid start bit), sample `rx_s`.
    - `rx_s`==1 → IDLE (glitch, no flags).
    - `rx_s`==0 → DATA, counter=0, bit=0.
  - DATA: every CLKS_PER_BIT cycles, shift `rx_s` into shift-reg bit[bit] (LSB first). After bit 7 → STOP.
  - STOP: after CLKS_PER_BIT cycles (mid stop bit), sample, then → IDLE in the same cycle.
    - `rx_s`==1 and output empty (or being accepted this cycle): urx_data<=shift, urx_valid<=1 next cycle.
    - `rx_s`==1 and urx_valid=1 and !urx_ready: urx_overrun pulses 1 cycle; the old byte is held and the new byte is discarded.
    - `rx_s`==0: urx_frame_err pulses 1 cycle; no byte is produced and the FSM still returns to IDLE. A continuous low line (break) therefore re-enters START immediately and repeats frame errors once per frame time.
- Timing from synchronized start edge to urx_valid=1: CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles.
- Output handshake:
  - urx_valid deasserts the cycle after valid & ready unless a new byte completes that same cycle.
  - Simultaneous accept + new byte: the new byte loads, urx_valid stays 1, no overrun.
- Returning to IDLE at mid stop bit absorbs up to ±half-bit baud error and permits back-to-back frames.
- Reset mid-frame: all state returns to reset values next cycle; a partial byte is never emitted. Reception resumes on the next falling edge seen after reset.

Decomposition:
- Package `svc_uart_pkg`:
  - FSM state enum (IDLE, START, DATA, STOP).
  - Function `clks_per_bit(freq, baud)`.
  - UART_DATA_BITS=8.
- Sharing the package lets a future `svc_uart_tx` use the same constants.
- One sub-module: `svc_sync_bit` (2-flop synchronizer with parameterized reset value, here 1).
- Counters are sized $clog2(CLKS_PER_BIT); there is no other hierarchy.

Test Plan:
- All scenarios use CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 (10 clocks/bit).
- Single byte: drive frame 0x55 with urx_ready=1 → urx_valid high exactly 1 cycle at start edge+2+96 cycles, urx_data=0x55, no error pulses.
- Back-to-back: drive 0xA5, 0x3C, 0xFF with no idle gap, urx_ready=1 → three bytes emitted in order, 100 cycles apart.
- Overrun: send 0x12 with urx_ready=0, then send 0x34 → urx_overrun pulses once at the 0x34 stop sample; urx_data stays 0x12. Raising ready then yields only 0x12.
- Framing error: send 0x81 with stop bit driven low → urx_frame_err single pulse, urx_valid stays 0. A following good 0x7E is received correctly.
- Glitch: 3-cycle low pulse on idle line → no valid and no flags; FSM back in IDLE by cycle 8. A subsequent 0x00 byte is received.
- Reset mid-frame: assert rst for 1 cycle during bit 4 of 0xC3 → no output for that frame. The next full frame 0x5A is received correctly.
